// File: rtl/decoded_instr_queue.sv
// Decoded-instruction FIFO between decode and issue. Buffers up to DEPTH entries with their
// control-flow flag and presents the oldest one to issue; flush empties it.
module decoded_instr_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1,
   parameter type scoreboard_entry_t = logic [63:0]
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  scoreboard_entry_t instr_i,
   input  logic              is_ctrl_flow_i,
   input  logic              instr_valid_i,
   output logic              instr_ready_o,
   output scoreboard_entry_t decoded_instr_o,
   output logic              is_ctrl_flow_o,
   output logic              decoded_instr_valid_o,
   input  logic              decoded_instr_ack_i,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef struct packed {
      scoreboard_entry_t instr;
      logic              ctrl;
   } slot_t;

   slot_t             mem_q [DEPTH];
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push, pop;

   // Ready and valid depend on registered occupancy only.
   assign instr_ready_o         = (count_q < CNT_W'(DEPTH));
   assign decoded_instr_valid_o = (count_q != '0);
   assign count_o               = count_q;

   assign push = instr_valid_i && instr_ready_o && !flush_i;
   assign pop  = decoded_instr_ack_i && decoded_instr_valid_o && !flush_i;

   // Empty queue shows zeros so stale storage never leaks out.
   assign decoded_instr_o = decoded_instr_valid_o ? mem_q[rptr_q].instr : '0;
   assign is_ctrl_flow_o  = decoded_instr_valid_o ? mem_q[rptr_q].ctrl  : 1'b0;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_W'(1);
         if (pop)  rptr_d = rptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= '{instr: instr_i, ctrl: is_ctrl_flow_i};
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push && count_q == CNT_W'(DEPTH)))
            else $error("push while full");
         assert (!(pop && count_q == '0))
            else $error("count underflow");
         assert (decoded_instr_valid_o == (count_o != '0))
            else $error("valid does not track count");
      end
   end
`endif

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Self-checking bench for decoded_instr_queue: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_decoded_instr_queue;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [7:0]  op;
   } sb_t;

   typedef struct packed {
      sb_t  e;
      logic c;
   } item_t;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   sb_t              instr = '0;
   logic             ctrl_in = 1'b0;
   logic             valid_in = 1'b0;
   logic             ready;
   sb_t              dout;
   logic             ctrl_out;
   logic             dvalid;
   logic             ack = 1'b0;
   logic [CNT_W-1:0] count;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;
   item_t model_q[$];

   decoded_instr_queue #(
      .DEPTH(DEPTH),
      .scoreboard_entry_t(sb_t)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .flush_i(flush),
      .instr_i(instr),
      .is_ctrl_flow_i(ctrl_in),
      .instr_valid_i(valid_in),
      .instr_ready_o(ready),
      .decoded_instr_o(dout),
      .is_ctrl_flow_o(ctrl_out),
      .decoded_instr_valid_o(dvalid),
      .decoded_instr_ack_i(ack),
      .count_o(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic sb_t mk(input logic [31:0] pc);
      sb_t s;
      s.pc = pc;
      s.rd = pc[6:2];
      s.op = pc[7:0] ^ 8'h5a;
      return s;
   endfunction

   // Compare DUT against the model every cycle, mid-period.
   always @(negedge clk) begin
      if (cmp_en) begin
         int sz;
         sb_t exp_e;
         logic exp_c;
         sz = model_q.size();
         exp_e = (sz != 0) ? model_q[0].e : '0;
         exp_c = (sz != 0) ? model_q[0].c : 1'b0;
         check("model_count", 64'(count), 64'(sz));
         check("model_valid", 64'(dvalid), 64'(sz != 0));
         check("model_ready", 64'(ready), 64'(sz < DEPTH));
         check("model_instr", 64'(dout), 64'(exp_e));
         check("model_ctrl", 64'(ctrl_out), 64'(exp_c));
      end
   end

   // Apply one cycle of inputs; the model sees the same inputs at the edge.
   task automatic step(input bit v, input bit a, input bit f, input sb_t e, input bit c);
      int sz;
      bit do_push, do_pop;
      valid_in = v; ack = a; flush = f; instr = e; ctrl_in = c;
      @(posedge clk);
      sz = model_q.size();
      if (f) begin
         model_q.delete();
      end else begin
         do_push = v && (sz < DEPTH);
         do_pop  = a && (sz > 0);
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back('{e: e, c: c});
      end
      #1;
      valid_in = 1'b0; ack = 1'b0; flush = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cmp_en = 1'b1;
      check("reset_valid", 64'(dvalid), 64'd0);
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_count", 64'(count), 64'd0);
      check("reset_instr", 64'(dout), 64'd0);
      check("reset_ctrl", 64'(ctrl_out), 64'd0);

      step(0, 1, 0, '0, 0);
      check("ack_empty_count", 64'(count), 64'd0);

      // Fill then drain in order.
      for (int i = 0; i < 4; i++) step(1, 0, 0, mk(32'h100 + 32'(4 * i)), i[0]);
      check("full_count", 64'(count), 64'd4);
      check("full_ready", 64'(ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", 64'(dout.pc), 64'(32'h100 + 32'(4 * i)));
         step(0, 1, 0, '0, 0);
      end
      check("drained_count", 64'(count), 64'd0);

      // Simultaneous push/pop at count 2 across the pointer wrap.
      step(1, 0, 0, mk(32'h200), 0);
      step(1, 0, 0, mk(32'h204), 0);
      for (int i = 0; i < 6; i++) begin
         check("pp_pc", 64'(dout.pc), 64'(32'h200 + 32'(4 * i)));
         step(1, 1, 0, mk(32'h208 + 32'(4 * i)), 0);
         check("pp_count", 64'(count), 64'd2);
      end
      check("pp_head", 64'(dout.pc), 64'h218);
      step(0, 1, 0, '0, 0);
      step(0, 1, 0, '0, 0);

      // Full with ack: no push this cycle, slot reopens next cycle.
      for (int i = 0; i < 4; i++) step(1, 0, 0, mk(32'h300 + 32'(4 * i)), 0);
      step(1, 1, 0, mk(32'h310), 0);
      check("fullack_count", 64'(count), 64'd3);
      check("fullack_ready", 64'(ready), 64'd1);
      step(1, 1, 0, mk(32'h314), 0);
      check("reopen_count", 64'(count), 64'd3);
      check("reopen_head", 64'(dout.pc), 64'h308);

      // Flush with simultaneous push and pop.
      step(1, 1, 1, mk(32'h400), 1);
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(dvalid), 64'd0);
      step(1, 0, 0, mk(32'h500), 0);
      check("post_flush_pc", 64'(dout.pc), 64'h500);
      check("post_flush_count", 64'(count), 64'd1);
      step(0, 1, 0, '0, 0);

      // Async reset between edges with a control-flow entry at the head.
      step(1, 0, 0, mk(32'h600), 1);
      step(1, 0, 0, mk(32'h604), 0);
      step(1, 0, 0, mk(32'h608), 0);
      check("pre_rst_ctrl", 64'(ctrl_out), 64'd1);
      #2;
      rst = 1'b1;
      model_q.delete();
      #1;
      check("async_valid", 64'(dvalid), 64'd0);
      check("async_count", 64'(count), 64'd0);
      check("async_ctrl", 64'(ctrl_out), 64'd0);
      check("async_instr", 64'(dout), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(9) < 7), ($urandom_range(9) < 6), ($urandom_range(19) == 0),
              mk($urandom()), 1'($urandom_range(1)));
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
